cache_controller: RTL

- Sequencing FSM for the direct-mapped instruction/data cache array: 32 lines × 4 words × 32 bits (128 words).
- Holds the tag and valid arrays, decides hit or miss for each RISC access and stalls the core.
- Drives the cache array enables/select lines and runs 4-word line refills from main memory.
- Write policy: write-through, no-write-allocate.

---
 rtl/cache_controller.sv | 131 +++++++++++++
 1 files changed

// File: rtl/cache_controller.sv
// Sequencing FSM for a direct-mapped 32-line x 4-word cache. It owns the tag and valid arrays,
// refills lines from memory on read misses, and writes through to memory without allocating on a miss.
module cache_controller #(
  parameter  int ADDR_W = 10,
  localparam int TAG_W  = ADDR_W - 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Risc_Read,
  input  logic              Risc_Write,
  input  logic [ADDR_W-1:0] Risc_Addr,
  output logic              Stall,
  output logic              Cache_Read_En,
  output logic              Cache_Write_En,
  output logic              Memory_Read_En,
  output logic              Mem_Done,
  output logic [4:0]        Line_number,
  output logic [1:0]        block_num_Addr,
  output logic [1:0]        block_num_Mem,
  output logic              Mem_Req,
  output logic              Mem_We,
  output logic [ADDR_W-1:0] Mem_Addr,
  input  logic              Mem_Ready,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WRITE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [31:0]      valid_q;
  logic [TAG_W-1:0] tag_q [32];

  logic [4:0]       idx;
  logic [TAG_W-1:0] addr_tag;
  logic             hit;
  logic             valid_clr, valid_set, tag_we;

  assign idx            = Risc_Addr[6:2];
  assign addr_tag       = Risc_Addr[ADDR_W-1:7];
  assign hit            = valid_q[idx] && (tag_q[idx] == addr_tag);
  assign Line_number    = idx;
  assign block_num_Addr = Risc_Addr[1:0];
  assign block_num_Mem  = cnt_q;
  assign dbg_state_o    = state_q;

  // Handshake: the core holds Risc_Read/Risc_Write and Risc_Addr until it samples Stall=0;
  // memory completes one word per Mem_Ready pulse while Mem_Req=1.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    Stall          = 1'b0;
    Cache_Read_En  = 1'b0;
    Cache_Write_En = 1'b0;
    Memory_Read_En = 1'b0;
    Mem_Done       = 1'b0;
    Mem_Req        = 1'b0;
    Mem_We         = 1'b0;
    Mem_Addr       = Risc_Addr;
    valid_clr      = 1'b0;
    valid_set      = 1'b0;
    tag_we         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (Risc_Read) begin
          if (hit) begin
            Cache_Read_En = 1'b1;
          end else begin
            // The line is invalidated up front so a partial refill can never look valid.
            Stall     = 1'b1;
            cnt_d     = 2'd0;
            valid_clr = 1'b1;
            state_d   = S_REFILL;
          end
        end else if (Risc_Write) begin
          Stall   = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_REFILL: begin
        Stall          = 1'b1;
        Mem_Req        = 1'b1;
        Memory_Read_En = 1'b1;
        Cache_Write_En = 1'b1;
        Mem_Done       = Mem_Ready;
        Mem_Addr       = {Risc_Addr[ADDR_W-1:2], cnt_q};
        if (Mem_Ready) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            valid_set = 1'b1;
            tag_we    = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_WRITE: begin
        Stall   = 1'b1;
        Mem_Req = 1'b1;
        Mem_We  = 1'b1;
        if (hit) begin
          Cache_Write_En = 1'b1;
          Mem_Done       = Mem_Ready;
        end
        if (Mem_Ready) state_d = S_DONE;
      end
      S_DONE: begin
        // Releases the core for one cycle so the held store is not taken again.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (valid_clr) valid_q[idx] <= 1'b0;
      if (valid_set) valid_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we && !rst) tag_q[idx] <= addr_tag;
  end

endmodule
